// File: rtl/bus_sram_slave.sv
// Memory-mapped SRAM slave for the valid/ready core bus: one transfer in flight,
// configurable wait states, byte/half/word lane writes and error responses.
module bus_sram_slave #(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] BASE    = 32'h0000_1000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic              valid,
    input  logic              write,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err
);

    localparam int                IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   LIMIT  = (ADDR_W+1)'(BASE) + (ADDR_W+1)'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic [IDX_W-1:0] idx_reg;
    logic [3:0]       be_reg;
    logic             wr_reg;
    logic             err_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      rdata_reg;

    logic [31:0] mem [DEPTH];

    // Decode of the live request, only meaningful in the acceptance cycle
    logic             req_hit;
    logic             req_align;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic [3:0]       req_be;

    assign req_hit = (addr >= BASE_A) && ({1'b0, addr} < LIMIT);
    assign req_idx = IDX_W'((addr - BASE_A) >> 2);
    assign req_err = !(req_hit && req_align);

    always_comb begin
        req_align = 1'b0;
        case (size)
            3'd0:    req_align = 1'b1;
            3'd1:    req_align = !addr[0];
            3'd2:    req_align = (addr[1:0] == 2'b00);
            default: req_align = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            localparam logic [1:0] LANE = 2'(gi);
            assign req_be[gi] = (size == 3'd2)
                             || (size == 3'd1 && addr[1] == LANE[1])
                             || (size == 3'd0 && addr[1:0] == LANE);
        end
    endgenerate

    logic             accept;
    logic             mem_we;
    logic             rd_load;
    logic             cur_wr;
    logic             cur_err;
    logic [IDX_W-1:0] cur_idx;

    assign accept = (state_reg == IDLE) && valid;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        cnt_next   = 4'(LATENCY - 1);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the memory read happens on the acceptance edge itself,
    // so the read port looks at the live request while idle.
    always_comb begin
        ready   = (state_reg == RESP);
        err     = (state_reg == RESP) && err_reg;
        mem_we  = (state_reg == RESP) && wr_reg && !err_reg;
        cur_wr  = (state_reg == IDLE) ? write   : wr_reg;
        cur_err = (state_reg == IDLE) ? req_err : err_reg;
        cur_idx = (state_reg == IDLE) ? req_idx : idx_reg;
        rd_load = (state_next == RESP) && (state_reg != RESP) && !cur_wr;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            idx_reg   <= '0;
            be_reg    <= 4'd0;
            wr_reg    <= 1'b0;
            err_reg   <= 1'b0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            idx_reg   <= req_idx;
            be_reg    <= req_be;
            wr_reg    <= write;
            err_reg   <= req_err;
            wdata_reg <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_reg[i]) mem[idx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rdata_reg <= 32'd0;
        end else if (rd_load) begin
            rdata_reg <= cur_err ? 32'd0 : mem[cur_idx];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: doc/bus_sram_slave.md
Name: bus_sram_slave

Overview:
- Parametrised memory-mapped SRAM slave for the core's simple valid/ready bus (addr, size, write, wdata, rdata).
- Successor to the fixed single-cycle bench RAM model: configurable base, depth and wait-state latency; byte/half/word lane writes; misalignment and out-of-range error reporting; one-transfer-at-a-time FSM.
- Serves as data memory beside stdout/stdin MMIO in simulation benches and FPGA top levels.

Parameters:
- ADDR_W, 32, bus address width.
- BASE, 32'h0000_1000, byte address of word 0; must be 4-byte aligned.
- DEPTH, 1024, number of 32-bit words, power of two ≥ 4.
- LATENCY, 1, cycles from acceptance to ready; range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstb  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  byte address of the request.
- size  in  3  0 = byte, 1 = half, 2 = word; 3..7 illegal.
- valid  in  1  request present; held by the master until ready.
- write  in  1  1 = write, 0 = read.
- wdata  in  32  write data, already placed on its byte lanes (byte at addr[1:0] on lane addr[1:0]).
- rdata  out  32  full aligned word containing addr; registered.
- ready  out  1  one-cycle response strobe.
- err  out  1  qualifies ready: access was rejected.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE, ready=0, err=0, rdata=0, wait counter=0. Memory contents are not cleared.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: when valid=1, latch addr, size, write and wdata.
  - LATENCY=1: go directly to RESP.
  - LATENCY>1: load counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter; go to RESP when the counter reaches 1.
- RESP: ready=1 for exactly one cycle, then IDLE.
- Latency: ready is high LATENCY cycles after the acceptance edge. Maximum throughput is one transfer per LATENCY+1 cycles.
- Input changes after acceptance are ignored. valid still high in the cycle after ready is a new request.
- Decode:
  - hit = BASE ≤ addr < BASE+4*DEPTH.
  - word index = (addr-BASE)>>2, log2(DEPTH) bits.
- Error conditions: !hit; size ≥ 3; size=1 with addr[0]=1; size=2 with addr[1:0]≠0.
  - On error: no memory write, rdata=0 on the response, err=1 with ready.
- Writes commit in the RESP cycle using byte enables:
  - size 0: lane addr[1:0].
  - size 1: lanes addr[1]*2 and +1.
  - size 2: all four lanes.
  - Unselected lanes are unchanged.
- Reads sample the memory word in the RESP cycle; rdata updates on the ready edge and holds until the next read response. Write responses leave rdata unchanged.
- err=0 whenever ready=0.
- Reset mid-transaction (during WAIT or RESP): abort, no write is committed, return to IDLE. The master must reissue.
- Memory is inferable as block RAM (byte-enable write, synchronous read). No read-during-write hazard, since only one transfer is in flight at a time.

Test Plan:
- Reset check: rstb low 2 cycles, then high with valid=0 -> ready=0, err=0, rdata=0 for 10 cycles.
- Word write/read, LATENCY=1: write addr=0x1000, size=2, wdata=0xDEADBEEF, then read 0x1000 -> each ready exactly 1 cycle after acceptance; rdata=0xDEADBEEF, err=0.
- Byte/half lanes: after the above, write byte 0x1002 (wdata=0x00550000), then half 0x1000 (wdata=0x00001234) -> read 0x1000 returns 0xDE551234.
- Errors: word write to 0x1002; read of 0x0FFC; read of BASE+4*DEPTH; size=3 -> each gives ready with err=1 and rdata=0 on reads; memory unchanged on re-read.
- LATENCY=4 back-to-back: valid held high for 3 reads of 0x1000/0x1004/0x1008 -> ready at cycles 4, 9, 14 after the first acceptance; correct data each; addr changed during WAIT is ignored.
- Reset abort: LATENCY=4, write 0x1004=0xAAAAAAAA, pull rstb low in WAIT -> after reset, reading 0x1004 returns the prior contents; ready/err/rdata are 0 during reset.
